usb_bus_scheduler: RTL and testbench
====================================

// Module: usb_bus_scheduler
// PURPOSE
//  Time-shares the single 32-bit FT60x 245-sync FIFO bus between the TX path (FPGA->host) and the RX path (host->FPGA).
//  Sits in the CLK_FTDI domain between the gateway's TX/RX FIFOs and the usb_* pins.
//  Grants bounded bursts with round-robin fairness, sequences OE-before-RD, and inserts bus turnaround.
// PARAMETERS
//  MAX_TX_BURST  256  max words per TX burst (>=1)
//  MAX_RX_BURST  256  max words per RX burst (>=1)
//  TURN_CYCLES   1    idle cycles after every burst, no strobe and no drive (>=1)
//  CNT_W         9    burst counter width; must hold max(MAX_TX_BURST, MAX_RX_BURST)
// PORTS
//  clk_in        in   1   bus clock (CLK_FTDI, 100 MHz)
//  rst_in        in   1   synchronous reset, active-high
//  en_in         in   1   1 = new bursts may start
//  usb_txe       in   1   active-high: FT60x can accept a word
//  usb_rxf       in   1   active-high: FT60x holds a word for us
//  tx_valid      in   1   TX FIFO (show-ahead) has a word at its output
//  rx_ready      in   1   RX FIFO can accept a word
//  usb_wr        out  1   active-high write strobe to pins (inverted at top)
//  usb_rd        out  1   active-high read strobe
//  usb_oe        out  1   active-high output-enable request to FT60x
//  bus_drive     out  1   1 = FPGA drives DATA/BE tristates
//  tx_pop        out  1   pop TX FIFO this cycle
//  rx_push       out  1   push DATA/BE into RX FIFO this cycle
//  state_out     out  3   current FSM state (debug)
//  tx_words      out  32  total words written; wraps
//  rx_words      out  32  total words read; wraps
// BEHAVIOUR
//  Reset: state=IDLE; last_grant=RX, so TX wins the first tie.
//  Reset: every output is 0, including the counters.
//  Reset mid-burst: all strobes and bus_drive are low on the cycle after rst_in is sampled high.
//  A partial burst is abandoned; no turnaround cycle is inserted.
//  States: IDLE=0, TX_BURST=1, RX_OE=2, RX_BURST=3, TURN=4. Registered FSM.
//  Strobes are combinational from state and inputs.
//  tx_req = en_in & usb_txe & tx_valid.
//  rx_req = en_in & usb_rxf & rx_ready.
//  IDLE, one request only: go to that path (TX->TX_BURST, RX->RX_OE).
//  IDLE, both requests: grant the path that is not last_grant.
//  IDLE, neither request: stay in IDLE.
//  Granting updates last_grant and clears burst_cnt.
//  TX_BURST: bus_drive=1; usb_wr = tx_pop = usb_txe & tx_valid.
//  TX_BURST: each usb_wr cycle increments burst_cnt and tx_words.
//  TX_BURST exits to TURN when any of these hold:
//   - a word is written while burst_cnt == MAX_TX_BURST-1
//   - usb_txe==0 or tx_valid==0 (no word moves that cycle)
//   - en_in==0 (no word moves that cycle)
//  RX_OE: exactly 1 cycle; usb_oe=1, usb_rd=0, bus_drive=0; then go to RX_BURST.
//  RX_BURST: usb_oe=1; usb_rd = rx_push = usb_rxf & rx_ready.
//  RX_BURST: each push increments burst_cnt and rx_words.
//  RX_BURST exit rules mirror TX_BURST, with MAX_RX_BURST, usb_rxf and rx_ready.
//  TURN: all strobes 0 and bus_drive=0 for TURN_CYCLES cycles, then IDLE.
//  TURN: requests are not sampled until IDLE.
//  Invariants:
//   - bus_drive and usb_oe are never both 1
//   - usb_wr and usb_rd are never both 1
//   - bus_drive=0 in every cycle where usb_oe=1 or the previous cycle had usb_oe=1
//  en_in deasserted mid-burst: the burst ends without moving a word that cycle.
//  Once en_in is low, no new burst starts.
//  Word counters are 32-bit and wrap 0xFFFFFFFF->0.
//  burst_cnt never exceeds the MAX value of the active burst.
// STRUCTURE
//  usb_fifo_defs.vh (shared include):
//   - state encodings ST_IDLE..ST_TURN
//   - GRANT_TX=0 / GRANT_RX=1
//  Sub-module usb_rr_arbiter: 2-way round-robin; inputs req_tx, req_rx, upd; outputs gnt_tx, gnt_rx and last_grant register.
//  FSM, burst counter, turnaround counter and word counters live in the top of this block.
// TESTING
//  Reset, then tx_valid=1, usb_txe=1, rx side idle, MAX_TX_BURST=4:
//   -> usb_wr/tx_pop high for exactly 4 cycles, 1 TURN cycle, then a new 4-word burst; tx_words=8 after 2 bursts.
//  TX and RX requesting continuously, defaults, MAX=4:
//   -> grants alternate TX,RX,TX; each RX burst is 1 OE-only cycle followed by 4 usb_rd cycles.
//  usb_txe drops after 2 words of a 4-word burst:
//   -> no usb_wr that cycle, TURN follows, burst_cnt is cleared on the next grant; tx_words=2.
//  rx_ready toggles 1,0,1,1 during an RX burst:
//   -> burst ends at the first 0; rx_push count equals the number of usb_rd cycles; usb_rd never high while usb_oe is low.
//  rst_in pulsed in the middle of an RX burst:
//   -> the next cycle shows usb_oe=usb_rd=bus_drive=0, state_out=0, rx_words=0.
//  Preload tx_words=0xFFFFFFFE (force), write 3 words:
//   -> tx_words=1; assertions for every invariant hold across all scenarios.

Source files
------------

// File: rtl/usb_bus_scheduler_pkg.sv
// Shared definitions for the FT60x bus scheduler: FSM state encodings,
// arbiter grant encodings and common widths.
package usb_bus_scheduler_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned WORD_W  = 32;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_TX_BURST = 3'd1,
      ST_RX_OE    = 3'd2,
      ST_RX_BURST = 3'd3,
      ST_TURN     = 3'd4
   } state_e;

   // Encoding of the arbiter's last_grant register
   localparam logic GRANT_TX = 1'b0;
   localparam logic GRANT_RX = 1'b1;

endpackage

// File: rtl/usb_rr_arbiter.sv
// Two-way round-robin arbiter between the TX and RX paths.
// Ports:
//   clk_in, rst_in  : clock, synchronous active-high reset
//   req_tx, req_rx  : path requests
//   upd             : commit the current grant into last_grant
//   gnt_tx, gnt_rx  : one-hot (or zero) combinational grant
// last_grant resets to RX so TX wins the first tie.
module usb_rr_arbiter
   import usb_bus_scheduler_pkg::*;
(
   input  logic clk_in,
   input  logic rst_in,
   input  logic req_tx,
   input  logic req_rx,
   input  logic upd,
   output logic gnt_tx,
   output logic gnt_rx
);

   logic last_grant_q;
   logic last_grant_d;

   // On a tie, the path that did not win last time is granted
   always_comb begin
      gnt_tx       = req_tx & (~req_rx | (last_grant_q == GRANT_RX));
      gnt_rx       = req_rx & ~gnt_tx;
      last_grant_d = last_grant_q;
      if (upd && gnt_tx) begin
         last_grant_d = GRANT_TX;
      end else if (upd && gnt_rx) begin
         last_grant_d = GRANT_RX;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         last_grant_q <= GRANT_RX;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/usb_bus_scheduler.sv
// Time-shares the 32-bit FT60x 245-sync FIFO bus between the TX path
// (FPGA->host) and the RX path (host->FPGA). Grants bounded bursts with
// round-robin fairness, sequences OE one cycle before RD, and inserts
// idle turnaround cycles after every burst.
// Ports:
//   clk_in, rst_in      : bus clock, synchronous active-high reset
//   en_in               : allow new bursts / word movement
//   usb_txe, usb_rxf    : FT60x can accept / holds a word
//   tx_valid, rx_ready  : TX FIFO has a word / RX FIFO has room
//   usb_wr, usb_rd      : active-high strobes (combinational)
//   usb_oe, bus_drive   : FT60x output enable / FPGA tristate enable
//   tx_pop, rx_push     : FIFO handshakes, equal to usb_wr / usb_rd
//   state_out           : current FSM state
//   tx_words, rx_words  : wrapping total word counters
module usb_bus_scheduler
   import usb_bus_scheduler_pkg::*;
#(
   parameter int unsigned MAX_TX_BURST = 256,
   parameter int unsigned MAX_RX_BURST = 256,
   parameter int unsigned TURN_CYCLES  = 1,
   parameter int unsigned CNT_W        = 9
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                en_in,
   input  logic                usb_txe,
   input  logic                usb_rxf,
   input  logic                tx_valid,
   input  logic                rx_ready,
   output logic                usb_wr,
   output logic                usb_rd,
   output logic                usb_oe,
   output logic                bus_drive,
   output logic                tx_pop,
   output logic                rx_push,
   output logic [STATE_W-1:0]  state_out,
   output logic [WORD_W-1:0]   tx_words,
   output logic [WORD_W-1:0]   rx_words
);

   localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_d;
   logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;
   logic [WORD_W-1:0]   tx_words_q, tx_words_d;
   logic [WORD_W-1:0]   rx_words_q, rx_words_d;

   logic tx_req, rx_req;
   logic gnt_tx, gnt_rx;
   logic arb_upd;
   logic tx_move, rx_move;

   assign tx_req = en_in & usb_txe & tx_valid;
   assign rx_req = en_in & usb_rxf & rx_ready;

   usb_rr_arbiter u_arb (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .req_tx (tx_req),
      .req_rx (rx_req),
      .upd    (arb_upd),
      .gnt_tx (gnt_tx),
      .gnt_rx (gnt_rx)
   );

   // Next-state, counters and strobes
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      turn_cnt_d  = turn_cnt_q;
      tx_words_d  = tx_words_q;
      rx_words_d  = rx_words_q;
      arb_upd     = 1'b0;
      tx_move     = 1'b0;
      rx_move     = 1'b0;
      usb_oe      = 1'b0;
      bus_drive   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            arb_upd = 1'b1;
            if (gnt_tx) begin
               state_d     = ST_TX_BURST;
               burst_cnt_d = '0;
            end else if (gnt_rx) begin
               state_d     = ST_RX_OE;
               burst_cnt_d = '0;
            end
         end
         ST_TX_BURST: begin
            bus_drive = 1'b1;
            // en_in gates the strobe so a disable ends the burst cleanly
            tx_move   = tx_req;
            if (tx_move) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
               tx_words_d  = tx_words_q + WORD_W'(1);
            end
            if (!tx_move || burst_cnt_q == CNT_W'(MAX_TX_BURST - 1)) begin
               state_d    = ST_TURN;
               turn_cnt_d = '0;
            end
         end
         ST_RX_OE: begin
            // FT60x needs OE a cycle ahead of the first RD
            usb_oe  = 1'b1;
            state_d = ST_RX_BURST;
         end
         ST_RX_BURST: begin
            usb_oe  = 1'b1;
            rx_move = rx_req;
            if (rx_move) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
               rx_words_d  = rx_words_q + WORD_W'(1);
            end
            if (!rx_move || burst_cnt_q == CNT_W'(MAX_RX_BURST - 1)) begin
               state_d    = ST_TURN;
               turn_cnt_d = '0;
            end
         end
         ST_TURN: begin
            if (turn_cnt_q == TURN_W'(TURN_CYCLES - 1)) begin
               state_d = ST_IDLE;
            end else begin
               turn_cnt_d = turn_cnt_q + TURN_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= '0;
         turn_cnt_q  <= '0;
         tx_words_q  <= '0;
         rx_words_q  <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         turn_cnt_q  <= turn_cnt_d;
         tx_words_q  <= tx_words_d;
         rx_words_q  <= rx_words_d;
      end
   end

   assign usb_wr    = tx_move;
   assign tx_pop    = tx_move;
   assign usb_rd    = rx_move;
   assign rx_push   = rx_move;
   assign state_out = state_q;
   assign tx_words  = tx_words_q;
   assign rx_words  = rx_words_q;

endmodule

// File: tb/tb_usb_bus_scheduler.sv
// Scoreboard bench for usb_bus_scheduler with 4-word bursts.
module tb_usb_bus_scheduler;
   import usb_bus_scheduler_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        en_in = 1'b0, usb_txe = 1'b0, usb_rxf = 1'b0;
   logic        tx_valid = 1'b0, rx_ready = 1'b0;
   logic        usb_wr, usb_rd, usb_oe, bus_drive, tx_pop, rx_push;
   logic [2:0]  state_out;
   logic [31:0] tx_words, rx_words;

   int n_tests = 0;
   int n_fail  = 0;
   logic prev_oe = 1'b0;

   // stimulus {rst, en, txe, txv, rxf, rxr}
   localparam logic [5:0] S_RST = 6'b100000;
   localparam logic [5:0] S_OFF = 6'b000000;
   localparam logic [5:0] S_TX  = 6'b011100;
   localparam logic [5:0] S_RX  = 6'b010011;
   localparam logic [5:0] S_ALL = 6'b011111;
   // expected {wr, rd, oe, drive, pop, push, state}
   localparam logic [8:0] E_I  = 9'b0000_00_000;
   localparam logic [8:0] E_TW = 9'b1001_10_001;
   localparam logic [8:0] E_TN = 9'b0001_00_001;
   localparam logic [8:0] E_OE = 9'b0010_00_010;
   localparam logic [8:0] E_RR = 9'b0110_01_011;
   localparam logic [8:0] E_RN = 9'b0010_00_011;
   localparam logic [8:0] E_U  = 9'b0000_00_100;

   logic [5:0] stim_q[$];
   logic [8:0] exp_q[$];

   usb_bus_scheduler #(
      .MAX_TX_BURST (4),
      .MAX_RX_BURST (4),
      .TURN_CYCLES  (1),
      .CNT_W        (9)
   ) dut (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .en_in     (en_in),
      .usb_txe   (usb_txe),
      .usb_rxf   (usb_rxf),
      .tx_valid  (tx_valid),
      .rx_ready  (rx_ready),
      .usb_wr    (usb_wr),
      .usb_rd    (usb_rd),
      .usb_oe    (usb_oe),
      .bus_drive (bus_drive),
      .tx_pop    (tx_pop),
      .rx_push   (rx_push),
      .state_out (state_out),
      .tx_words  (tx_words),
      .rx_words  (rx_words)
   );

   initial forever #5 clk_in = ~clk_in;

   function automatic logic [8:0] obs();
      return {usb_wr, usb_rd, usb_oe, bus_drive, tx_pop, rx_push, state_out};
   endfunction

   // queue n cycles of one stimulus and its expected output
   task automatic sched(input logic [5:0] s, input logic [8:0] e, input int n);
      for (int i = 0; i < n; i++) begin
         stim_q.push_back(s);
         exp_q.push_back(e);
      end
   endtask

   // one cycle: inputs change 1 after the edge, outputs settle 1 later
   task automatic drive(input logic [5:0] s);
      prev_oe = usb_oe;
      @(posedge clk_in);
      #1;
      {rst_in, en_in, usb_txe, tx_valid, usb_rxf, rx_ready} = s;
      #1;
   endtask

   task automatic test_reset();
      drive(S_RST);
      drive(S_RST);
      n_tests++;
      if (obs() !== 9'd0) begin
         n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs(), 9'd0);
      end
      n_tests++;
      if (tx_words !== 32'd0) begin
         n_fail++; $display("FAIL reset_tx_words got=%0d want=0", tx_words);
      end
      n_tests++;
      if (rx_words !== 32'd0) begin
         n_fail++; $display("FAIL reset_rx_words got=%0d want=0", rx_words);
      end
   endtask

   task automatic test_tx_bursts();
      logic [8:0] want;
      sched(S_TX, E_I, 1);  sched(S_TX, E_TW, 4); sched(S_TX, E_U, 1);
      sched(S_TX, E_I, 1);  sched(S_TX, E_TW, 4); sched(S_OFF, E_U, 1);
      sched(S_OFF, E_I, 1);
      for (int c = 0; stim_q.size() > 0; c++) begin
         drive(stim_q.pop_front());
         want = exp_q.pop_front();
         n_tests++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL tx_bursts cyc%0d got=%b want=%b", c, obs(), want);
         end
         if ((bus_drive && usb_oe) || (usb_wr && usb_rd) || (bus_drive && prev_oe)) begin
            n_fail++; $display("FAIL invariant tx_bursts cyc%0d", c);
         end
      end
      n_tests++;
      if (tx_words !== 32'd8) begin
         n_fail++; $display("FAIL tx_bursts_words got=%0d want=8", tx_words);
      end
   endtask

   task automatic test_alternate();
      logic [8:0] want;
      sched(S_RST, E_I, 1);
      sched(S_ALL, E_I, 1); sched(S_ALL, E_TW, 4); sched(S_ALL, E_U, 1);
      sched(S_ALL, E_I, 1); sched(S_ALL, E_OE, 1); sched(S_ALL, E_RR, 4); sched(S_ALL, E_U, 1);
      sched(S_ALL, E_I, 1); sched(S_ALL, E_TW, 4); sched(S_OFF, E_U, 1);
      sched(S_OFF, E_I, 1);
      for (int c = 0; stim_q.size() > 0; c++) begin
         drive(stim_q.pop_front());
         want = exp_q.pop_front();
         n_tests++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL alternate cyc%0d got=%b want=%b", c, obs(), want);
         end
         if ((bus_drive && usb_oe) || (usb_wr && usb_rd) || (bus_drive && prev_oe)) begin
            n_fail++; $display("FAIL invariant alternate cyc%0d", c);
         end
      end
      n_tests++;
      if (tx_words !== 32'd8 || rx_words !== 32'd4) begin
         n_fail++; $display("FAIL alternate_words got=%0d/%0d want=8/4", tx_words, rx_words);
      end
   endtask

   task automatic test_txe_drop();
      logic [8:0] want;
      sched(S_RST, E_I, 1);
      sched(S_TX, E_I, 1); sched(S_TX, E_TW, 2); sched(6'b010100, E_TN, 1);
      sched(S_TX, E_U, 1);
      sched(S_TX, E_I, 1); sched(S_TX, E_TW, 4); sched(S_OFF, E_U, 1);
      sched(S_OFF, E_I, 1);
      for (int c = 0; stim_q.size() > 0; c++) begin
         drive(stim_q.pop_front());
         want = exp_q.pop_front();
         n_tests++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL txe_drop cyc%0d got=%b want=%b", c, obs(), want);
         end
         if ((bus_drive && usb_oe) || (usb_wr && usb_rd) || (bus_drive && prev_oe)) begin
            n_fail++; $display("FAIL invariant txe_drop cyc%0d", c);
         end
      end
      n_tests++;
      if (tx_words !== 32'd6) begin
         n_fail++; $display("FAIL txe_drop_words got=%0d want=6", tx_words);
      end
   endtask

   task automatic test_rx_ready_toggle();
      logic [8:0] want;
      sched(S_RST, E_I, 1);
      sched(S_RX, E_I, 1); sched(S_RX, E_OE, 1); sched(S_RX, E_RR, 1);
      sched(6'b010010, E_RN, 1); sched(6'b010001, E_U, 1); sched(6'b010001, E_I, 1);
      sched(S_OFF, E_I, 1);
      for (int c = 0; stim_q.size() > 0; c++) begin
         drive(stim_q.pop_front());
         want = exp_q.pop_front();
         n_tests++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL rx_toggle cyc%0d got=%b want=%b", c, obs(), want);
         end
         if ((bus_drive && usb_oe) || (usb_wr && usb_rd) || (bus_drive && prev_oe) ||
             (usb_rd && !usb_oe)) begin
            n_fail++; $display("FAIL invariant rx_toggle cyc%0d", c);
         end
      end
      n_tests++;
      if (rx_words !== 32'd1) begin
         n_fail++; $display("FAIL rx_toggle_words got=%0d want=1", rx_words);
      end
   endtask

   task automatic test_reset_mid_rx();
      logic [8:0] want;
      sched(S_RST, E_I, 1);
      sched(S_RX, E_I, 1); sched(S_RX, E_OE, 1); sched(S_RX, E_RR, 1);
      sched(6'b110011, E_RR, 1); sched(S_OFF, E_I, 1);
      for (int c = 0; stim_q.size() > 0; c++) begin
         drive(stim_q.pop_front());
         want = exp_q.pop_front();
         n_tests++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL reset_mid_rx cyc%0d got=%b want=%b", c, obs(), want);
         end
         if ((bus_drive && usb_oe) || (usb_wr && usb_rd) || (bus_drive && prev_oe)) begin
            n_fail++; $display("FAIL invariant reset_mid_rx cyc%0d", c);
         end
      end
      n_tests++;
      if (rx_words !== 32'd0 || state_out !== 3'd0) begin
         n_fail++; $display("FAIL reset_mid_rx_state got=%0d/%0d want=0/0", rx_words, state_out);
      end
   endtask

   task automatic test_wrap();
      logic [8:0] want;
      drive(S_RST);
      drive(S_OFF);
      force dut.tx_words_q = 32'hFFFF_FFFE;
      #1;
      release dut.tx_words_q;
      #1;
      n_tests++;
      if (tx_words !== 32'hFFFF_FFFE) begin
         n_fail++; $display("FAIL wrap_preload got=%h want=fffffffe", tx_words);
      end
      sched(S_TX, E_I, 1); sched(S_TX, E_TW, 3); sched(6'b011000, E_TN, 1);
      sched(S_OFF, E_U, 1); sched(S_OFF, E_I, 1);
      for (int c = 0; stim_q.size() > 0; c++) begin
         drive(stim_q.pop_front());
         want = exp_q.pop_front();
         n_tests++;
         if (obs() !== want) begin
            n_fail++; $display("FAIL wrap cyc%0d got=%b want=%b", c, obs(), want);
         end
         if ((bus_drive && usb_oe) || (usb_wr && usb_rd) || (bus_drive && prev_oe)) begin
            n_fail++; $display("FAIL invariant wrap cyc%0d", c);
         end
      end
      n_tests++;
      if (tx_words !== 32'd1) begin
         n_fail++; $display("FAIL wrap_words got=%h want=00000001", tx_words);
      end
   endtask

   initial begin
      test_reset();
      test_tx_bursts();
      test_alternate();
      test_txe_drop();
      test_rx_ready_toggle();
      test_reset_mid_rx();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
